// File: rtl/uart_rx_sampler.sv
// UART receive front end: rx_i synchroniser, start detect, 3-sample majority per bit, stop check; one-cycle rx_valid_o per frame.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits; there is no backpressure.
module uart_rx_sampler #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [31:0]          clk_div_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_err_o
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [31:0]            div_q;
  logic [31:0]            cnt_q;
  logic [IW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   samp_a_q;
  logic                   samp_b_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q;
`endif

  logic        rx_s;
  logic        fall;
  logic [31:0] div_in;
  logic [31:0] half;
  logic        at_first, at_mid, at_dec, at_end;
  logic        dec;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = prev_q & ~rx_s;
  assign div_in   = (clk_div_i < 32'(MIN_DIV)) ? 32'(MIN_DIV) : clk_div_i;
  assign half     = div_q >> 1;
  assign at_first = (cnt_q == half - 32'd1);
  assign at_mid   = (cnt_q == half);
  assign at_dec   = (cnt_q == half + 32'd1);
  assign at_end   = (cnt_q == div_q - 32'd1);
  // Third sample is the live rx_s at the decision count.
  assign dec      = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= at_end ? '0 : cnt_q + 32'd1;
        if (at_first) samp_a_q <= rx_s;
        if (at_mid)   samp_b_q <= rx_s;
      end
      case (state_q)
        IDLE: begin
          // The detect cycle itself is count 0, so the next cycle is count 1.
          if (fall) begin
            state_q   <= START;
            cnt_q     <= 32'd1;
            div_q     <= div_in;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (at_dec && dec) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (at_end) begin
            state_q <= DATA;
            idx_q   <= '0;
          end
        end
        DATA: begin
          if (at_dec) shift_q[idx_q] <= dec;
          if (at_end) begin
            if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_dec) par_err_q <= dec ^ (^shift_q);
          if (at_end) state_q <= STOP;
        end
`endif
        STOP: begin
          // Leave mid stop bit so a back-to-back start edge is seen.
          if (at_dec) begin
            rx_valid_o <= 1'b1;
            rx_data_o  <= shift_q;
`ifdef UART_RX_PARITY_EN
            rx_err_o   <= ~dec | par_err_q;
`else
            rx_err_o   <= ~dec;
`endif
            state_q    <= IDLE;
            cnt_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames pushed to a scoreboard when driven, popped on each rx_valid_o pulse.
module tb_uart_rx_sampler;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] clk_div_i = 32'd16;
  logic        rx_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_err_o;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = 0;
  int   last_drive_cyc = 0;
  logic prev_vld = 1'b0;

  uart_rx_sampler #(.DATA_BITS(8), .SYNC_STAGES(SYNC), .MIN_DIV(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div_i  (clk_div_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_err_o   (rx_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && rx_valid_o) begin
      exp_t e;
      check("single_cycle_pulse", {31'd0, prev_vld}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, rx_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data_o}, {24'd0, e.data});
        check("rx_err", {31'd0, rx_err_o}, {31'd0, e.err});
      end
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
    prev_vld = rx_valid_o;
  end

  task automatic drive_bit(input logic b, input int n);
    @(posedge clk);
    #1 rx_i = b;
    last_drive_cyc = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (n - 1) @(posedge clk);
  endtask

  // Returns the cycle of the edge preceding the start-bit fall.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int bit_len, input logic [31:0] cfg_div,
                            input logic [31:0] mid_div, output int t0);
    exp_t e;
    e.data = d;
    e.err  = ~stop_b;
`ifdef UART_RX_PARITY_EN
    e.err  = e.err | (par_b != ^d);
`endif
    exp_q.push_back(e);
    clk_div_i = cfg_div;
    drive_bit(1'b0, bit_len);
    t0 = last_drive_cyc;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) clk_div_i = mid_div;
      drive_bit(d[i], bit_len);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, bit_len);
`endif
    clk_div_i = cfg_div;
    drive_bit(stop_b, bit_len);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("pulse_wait", pulse_cnt, target);
  endtask

  initial begin
    int t0;
    int lat;
    int base;

    #1;
    check("reset_data", {24'd0, rx_data_o}, 32'd0);
    check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    check("reset_err", {31'd0, rx_err_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(10);

    // Clean 0xA5 at D=16, with end-to-end latency.
    send_frame(8'hA5, 1'b1, ^(8'hA5), 16, 32'd16, 32'd16, t0);
    wait_pulses(1, 200);
    lat = SYNC + 9 * 16 + 8 + 2;
`ifdef UART_RX_PARITY_EN
    lat = lat + 16;
`endif
    check("latency", last_pulse_cyc - t0, lat);
    idle(20);

    // Three-cycle glitch is rejected by the start-bit majority vote.
    drive_bit(1'b0, 3);
    idle(60);
    check("glitch_no_pulse", pulse_cnt, 1);
    check("glitch_data_held", {24'd0, rx_data_o}, 32'h0000_00A5);
    check("glitch_err_held", {31'd0, rx_err_o}, 32'd0);

    // Framing error followed by a held-low break.
    send_frame(8'h3C, 1'b0, ^(8'h3C), 16, 32'd16, 32'd16, t0);
    wait_pulses(2, 200);
    drive_bit(1'b0, 40);
    check("break_no_frame", pulse_cnt, 2);
    check("break_err_held", {31'd0, rx_err_o}, 32'd1);
    idle(20);

    // Reset during data bits of 0xFF aborts without a pulse.
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    #2 rstn = 1'b0;
    #1;
    check("abort_data", {24'd0, rx_data_o}, 32'd0);
    check("abort_valid", {31'd0, rx_valid_o}, 32'd0);
    check("abort_err", {31'd0, rx_err_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(20);
    check("abort_no_pulse", pulse_cnt, 2);

    send_frame(8'h5A, 1'b1, ^(8'h5A), 16, 32'd16, 32'd16, t0);
    wait_pulses(3, 200);
    idle(20);

    // clk_div_i=2 clamps to 4; back-to-back frames, divider disturbed mid-frame.
    clk_div_i = 32'd2;
    idle(10);
    base = pulse_cnt;
    send_frame(8'h00, 1'b1, ^(8'h00), 4, 32'd2, 32'd50, t0);
    send_frame(8'hFF, 1'b1, ^(8'hFF), 4, 32'd2, 32'd2, t0);
    idle(20);
    wait_pulses(base + 2, 200);

`ifdef UART_RX_PARITY_EN
    clk_div_i = 32'd16;
    idle(10);
    send_frame(8'h01, 1'b1, 1'b0, 16, 32'd16, 32'd16, t0);
    wait_pulses(base + 3, 200);
    idle(10);
    send_frame(8'h01, 1'b1, 1'b1, 16, 32'd16, 32'd16, t0);
    wait_pulses(base + 4, 200);
    idle(10);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
